// File: rtl/cw_sequencer_pkg.sv
// cw_sequencer_pkg: control-word field positions, register indices, opcode and FSM enums shared by the sequencer and the encoder
package cw_sequencer_pkg;
  localparam int PS_LSB = 30;
  localparam int DA_LSB = 25;
  localparam int SA_LSB = 20;
  localparam int SB_LSB = 15;
  localparam int FS_LSB = 10;
  localparam int RW_BIT = 9;
  localparam int MW_BIT = 8;
  localparam int MD_BIT = 7;
  localparam int AD_BIT = 6;
  localparam int RD_BIT = 5;
  localparam int PD_BIT = 4;
  localparam int BS_BIT = 3;
  localparam int PV_BIT = 2;
  localparam int SU_BIT = 1;
  localparam int CI_BIT = 0;
  localparam logic [4:0] ZERO_REG = 5'd31;
  localparam logic [4:0] SCRATCH_REG = 5'd30;
  localparam logic [4:0] FS_ADD = 5'b00100;
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [31:0] NOP_WORD = {PS_HOLD, 30'b0};
  // member order matches word bits [9:0], MSB first
  typedef struct packed {
    logic rw, mw, md, ad, rd, pd, bs, pv, su, ci;
  } flags_t;
  typedef enum logic [1:0] {OP_LOAD_REG, OP_STORE_RAM, OP_LOAD_RAM, OP_READ_REG} op_t;
  typedef enum logic [1:0] {IDLE, EX1, EX2, DONE} state_t;
endpackage

// File: rtl/cw_encode.sv
// cw_encode: combinational packer of datapath control-word fields into a 32-bit word
module cw_encode
  import cw_sequencer_pkg::*;
(
  input  logic [1:0]  ps,
  input  logic [4:0]  da,
  input  logic [4:0]  sa,
  input  logic [4:0]  sb,
  input  logic [4:0]  fs,
  input  logic [9:0]  flags,
  output logic [31:0] word
);
  always_comb begin
    word = '0;
    word[PS_LSB +: 2] = ps;
    word[DA_LSB +: 5] = da;
    word[SA_LSB +: 5] = sa;
    word[SB_LSB +: 5] = sb;
    word[FS_LSB +: 5] = fs;
    word[RW_BIT:CI_BIT] = flags;
  end
endmodule

// File: rtl/cw_sequencer.sv
// cw_sequencer: expands host commands into datapath control words; rst is async active-low.
// Build with CW_SEQ_COUNT_EN defined to get the issued-word counter on cw_count.
module cw_sequencer
  import cw_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_reg,
  input  logic [63:0] cmd_addr,
  input  logic [63:0] cmd_data,
  input  logic [63:0] reg_a_data,
  output logic [31:0] control_word,
  output logic [63:0] constant_value,
  output logic        cw_valid,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        done,
  output logic        err,
  output logic [31:0] cw_count
);
  state_t state, state_n;
  op_t op_q, op_c;
  logic [4:0] reg_q, reg_c, da, sa, sb;
  logic [63:0] addr_q, data_q, addr_c, data_c, const_n;
  logic hs, reject, valid_n;
  flags_t fl;
  logic [31:0] word;
  assign cmd_ready = state == IDLE;
  assign hs = cmd_valid && cmd_ready;
  // in IDLE the command is still on the inputs; afterwards use the latched copy
  assign op_c = cmd_ready ? op_t'(cmd_op) : op_q;
  assign reg_c = cmd_ready ? cmd_reg : reg_q;
  assign addr_c = cmd_ready ? cmd_addr : addr_q;
  assign data_c = cmd_ready ? cmd_data : data_q;
  assign reject = (op_c == OP_LOAD_REG || op_c == OP_LOAD_RAM) && reg_c == ZERO_REG;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = hs ? (reject ? DONE : EX1) : IDLE;
      EX1:  state_n = op_q == OP_STORE_RAM ? EX2 : DONE;
      EX2:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered, so the word is built for the state being entered
  always_comb begin
    da = '0;
    sa = ZERO_REG;
    sb = '0;
    fl = '0;
    const_n = '0;
    valid_n = state_n == EX1 || state_n == EX2;
    if (state_n == EX2) begin
      sb = SCRATCH_REG;
      fl.mw = 1'b1;
      const_n = addr_c;
    end else if (state_n == EX1) begin
      case (op_c)
        OP_LOAD_REG: begin
          da = reg_c;
          fl.rw = 1'b1;
          fl.ad = 1'b1;
          const_n = data_c;
        end
        OP_STORE_RAM: begin
          da = SCRATCH_REG;
          fl.rw = 1'b1;
          fl.ad = 1'b1;
          const_n = data_c;
        end
        OP_LOAD_RAM: begin
          da = reg_c;
          fl.rw = 1'b1;
          fl.md = 1'b1;
          const_n = addr_c;
        end
        default: sa = reg_c;
      endcase
    end
  end
  cw_encode u_encode (
    .ps(PS_HOLD), .da(da), .sa(sa), .sb(sb), .fs(FS_ADD), .flags(fl), .word(word)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q <= OP_LOAD_REG;
      reg_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      control_word <= NOP_WORD;
      constant_value <= '0;
      cw_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (hs) begin
        op_q <= op_t'(cmd_op);
        reg_q <= cmd_reg;
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end
      control_word <= valid_n ? word : NOP_WORD;
      constant_value <= const_n;
      cw_valid <= valid_n;
      done <= state_n == DONE;
      err <= state_n == DONE && state == IDLE;
      rsp_valid <= state == EX1 && op_q == OP_READ_REG;
      if (state == EX1 && op_q == OP_READ_REG) rsp_data <= reg_a_data;
    end
  end
`ifdef CW_SEQ_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cw_count <= '0;
    else cw_count <= cw_count + 32'(cw_valid);
  end
`else
  assign cw_count = '0;
`endif
endmodule

// File: tb/tb_cw_sequencer.sv
// tb_cw_sequencer: directed self-checking bench for cw_sequencer
module tb_cw_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [4:0] cmd_reg = '0;
  logic [63:0] cmd_addr = '0, cmd_data = '0, reg_a_data = '0;
  logic [31:0] control_word, cw_count;
  logic [63:0] constant_value, rsp_data;
  logic cw_valid, rsp_valid, done, err;
  int errs = 0, checks = 0;
  localparam logic [31:0] NOP = 32'h0;
  localparam logic [4:0] FS = 5'b00100;

  cw_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .reg_a_data(reg_a_data),
    .control_word(control_word), .constant_value(constant_value), .cw_valid(cw_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .err(err), .cw_count(cw_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] r, input logic [63:0] a, input logic [63:0] d);
    cmd_op = op; cmd_reg = r; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    step;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (control_word !== NOP) begin errs++; $display("FAIL reset_cw got=%h exp=%h", control_word, NOP); end
    checks++; if (constant_value !== 64'h0) begin errs++; $display("FAIL reset_const got=%h exp=0", constant_value); end
    checks++; if ({cw_valid, rsp_valid, done, err} !== 4'b0) begin errs++; $display("FAIL reset_flags got=%b exp=0000", {cw_valid, rsp_valid, done, err}); end
    checks++; if (rsp_data !== 64'h0) begin errs++; $display("FAIL reset_rsp got=%h exp=0", rsp_data); end
    checks++; if (cw_count !== 32'h0) begin errs++; $display("FAIL reset_count got=%0d exp=0", cw_count); end
    checks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    step;
    rst = 1'b1;
    step;
  endtask

  task automatic test_load_reg;
    issue(2'b00, 5'd5, 64'h0, 64'h1234);
    checks++; if (control_word !== {2'b00, 5'd5, 5'd31, 5'd0, FS, 10'b10_0100_0000}) begin errs++; $display("FAIL load_reg_cw got=%h", control_word); end
    checks++; if (constant_value !== 64'h1234) begin errs++; $display("FAIL load_reg_const got=%h exp=1234", constant_value); end
    checks++; if ({cw_valid, done, cmd_ready} !== 3'b100) begin errs++; $display("FAIL load_reg_ex1 got=%b exp=100", {cw_valid, done, cmd_ready}); end
    step;
    checks++; if ({cw_valid, done, err, cmd_ready} !== 4'b0100) begin errs++; $display("FAIL load_reg_done got=%b exp=0100", {cw_valid, done, err, cmd_ready}); end
    checks++; if (control_word !== NOP) begin errs++; $display("FAIL load_reg_nop got=%h exp=%h", control_word, NOP); end
    step;
    checks++; if ({done, cmd_ready} !== 2'b01) begin errs++; $display("FAIL load_reg_idle got=%b exp=01", {done, cmd_ready}); end
  endtask

  task automatic test_store_ram;
    issue(2'b01, 5'd9, 64'h10, 64'hDEADBEEF);
    checks++; if (control_word !== {2'b00, 5'd30, 5'd31, 5'd0, FS, 10'b10_0100_0000}) begin errs++; $display("FAIL store_ex1_cw got=%h", control_word); end
    checks++; if (constant_value !== 64'hDEADBEEF) begin errs++; $display("FAIL store_ex1_const got=%h exp=deadbeef", constant_value); end
    step;
    checks++; if (control_word !== {2'b00, 5'd0, 5'd31, 5'd30, FS, 10'b01_0000_0000}) begin errs++; $display("FAIL store_ex2_cw got=%h", control_word); end
    checks++; if (constant_value !== 64'h10) begin errs++; $display("FAIL store_ex2_const got=%h exp=10", constant_value); end
    checks++; if ({cw_valid, done} !== 2'b10) begin errs++; $display("FAIL store_ex2_flags got=%b exp=10", {cw_valid, done}); end
    step;
    checks++; if ({cw_valid, done, err} !== 3'b010) begin errs++; $display("FAIL store_done got=%b exp=010", {cw_valid, done, err}); end
    step;
  endtask

  task automatic test_load_ram;
    issue(2'b10, 5'd12, 64'h40, 64'h0);
    checks++; if (control_word !== {2'b00, 5'd12, 5'd31, 5'd0, FS, 10'b10_1000_0000}) begin errs++; $display("FAIL load_ram_cw got=%h", control_word); end
    checks++; if (constant_value !== 64'h40) begin errs++; $display("FAIL load_ram_const got=%h exp=40", constant_value); end
    step;
    checks++; if ({done, err, rsp_valid} !== 3'b100) begin errs++; $display("FAIL load_ram_done got=%b exp=100", {done, err, rsp_valid}); end
    step;
  endtask

  task automatic test_read_reg;
    issue(2'b11, 5'd7, 64'h0, 64'h0);
    reg_a_data = 64'hCAFE;
    checks++; if (control_word !== {2'b00, 5'd0, 5'd7, 5'd0, FS, 10'b0}) begin errs++; $display("FAIL read_cw got=%h", control_word); end
    checks++; if ({cw_valid, rsp_valid} !== 2'b10) begin errs++; $display("FAIL read_ex1 got=%b exp=10", {cw_valid, rsp_valid}); end
    step;
    reg_a_data = 64'h5555;
    checks++; if ({rsp_valid, done, err} !== 3'b110) begin errs++; $display("FAIL read_done got=%b exp=110", {rsp_valid, done, err}); end
    checks++; if (rsp_data !== 64'hCAFE) begin errs++; $display("FAIL read_data got=%h exp=cafe", rsp_data); end
    step;
    step;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 64'hCAFE) begin errs++; $display("FAIL read_hold got=%b/%h exp=0/cafe", rsp_valid, rsp_data); end
  endtask

  task automatic test_count;
    logic [31:0] exp_cnt;
`ifdef CW_SEQ_COUNT_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    checks++; if (cw_count !== exp_cnt) begin errs++; $display("FAIL count got=%0d exp=%0d", cw_count, exp_cnt); end
  endtask

  task automatic test_reject;
    issue(2'b10, 5'd31, 64'h80, 64'h0);
    checks++; if ({cw_valid, done, err, cmd_ready} !== 4'b0110) begin errs++; $display("FAIL reject_done got=%b exp=0110", {cw_valid, done, err, cmd_ready}); end
    checks++; if (control_word !== NOP) begin errs++; $display("FAIL reject_cw got=%h exp=%h", control_word, NOP); end
    step;
    checks++; if ({done, err, cmd_ready, cw_valid} !== 4'b0010) begin errs++; $display("FAIL reject_idle got=%b exp=0010", {done, err, cmd_ready, cw_valid}); end
    issue(2'b00, 5'd31, 64'h0, 64'h77);
    checks++; if ({cw_valid, done, err} !== 3'b011) begin errs++; $display("FAIL reject_load_reg got=%b exp=011", {cw_valid, done, err}); end
    step;
  endtask

  task automatic test_back_to_back;
    cmd_op = 2'b00; cmd_reg = 5'd30; cmd_data = 64'hAA; cmd_valid = 1'b1;
    step;
    cmd_reg = 5'd3; cmd_data = 64'hBB;
    checks++; if (control_word !== {2'b00, 5'd30, 5'd31, 5'd0, FS, 10'b10_0100_0000} || constant_value !== 64'hAA) begin errs++; $display("FAIL b2b_first got=%h/%h", control_word, constant_value); end
    step;
    checks++; if ({cw_valid, done, cmd_ready} !== 3'b010) begin errs++; $display("FAIL b2b_done got=%b exp=010", {cw_valid, done, cmd_ready}); end
    step;
    checks++; if ({cw_valid, done, cmd_ready} !== 3'b001) begin errs++; $display("FAIL b2b_gap got=%b exp=001", {cw_valid, done, cmd_ready}); end
    step;
    cmd_valid = 1'b0;
    checks++; if (control_word !== {2'b00, 5'd3, 5'd31, 5'd0, FS, 10'b10_0100_0000} || constant_value !== 64'hBB) begin errs++; $display("FAIL b2b_second got=%h/%h", control_word, constant_value); end
    step;
    step;
  endtask

  task automatic test_reset_mid;
    issue(2'b01, 5'd0, 64'h20, 64'h99);
    checks++; if (cw_valid !== 1'b1) begin errs++; $display("FAIL mid_ex1 got=%b exp=1", cw_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (control_word !== NOP || cw_valid !== 1'b0 || constant_value !== 64'h0) begin errs++; $display("FAIL mid_reset got=%h/%b/%h", control_word, cw_valid, constant_value); end
    checks++; if (cmd_ready !== 1'b1 || cw_count !== 32'h0) begin errs++; $display("FAIL mid_ready got=%b/%0d exp=1/0", cmd_ready, cw_count); end
    step;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++; if ({cw_valid, done, cmd_ready} !== 3'b001) begin errs++; $display("FAIL mid_after%0d got=%b exp=001", i, {cw_valid, done, cmd_ready}); end
    end
  endtask

  initial begin
    test_reset;
    test_load_reg;
    test_store_ram;
    test_load_ram;
    test_read_reg;
    test_count;
    test_reject;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
